mod_exp_ctrl: RTL and testbench
===============================

# mod_exp_ctrl

Left-to-right square-and-multiply sequencer computing result = base^exp mod m. It is the initiator side of the pulse-start / pulse-done modular-multiplier interface. It drives operands and a one-cycle start pulse into an external interleaved modular multiplier and consumes that multiplier's done pulse and product. It sits between the register/host layer and the multiplier core.

## Interface
Parameters:
- NBITS, 4096, width of base, modulus, result and multiplier operands
- EBITS, 4096, width of exponent

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start_p  in  1  one-cycle start pulse; samples base/exp/m
- base  in  NBITS  base, precondition base < m
- exp  in  EBITS  exponent
- m  in  NBITS  modulus, precondition m >= 2
- busy  out  1  high from the cycle after accepted start_p until done_irq_p
- result  out  NBITS  last completed result, held until next completion
- done_irq_p  out  1  one-cycle completion pulse
- mm_enable_p  out  1  one-cycle multiplier start pulse
- mm_a  out  NBITS  multiplier operand A (bit-scanned operand)
- mm_b  out  NBITS  multiplier operand B
- mm_m  out  NBITS  multiplier modulus
- mm_y  in  NBITS  multiplier product, valid in the cycle mm_done_irq_p is high
- mm_done_irq_p  in  1  multiplier one-cycle done pulse

## Operation
- Registers: base_r, m_r, e_r (EBITS), cnt (bits remaining, clog2(EBITS+1) bits), acc (NBITS).
- Reset values: busy=0, result=0, done_irq_p=0, mm_enable_p=0, mm_a=mm_b=mm_m=0, state=IDLE.
- IDLE: on start_p, load base_r, m_r, e_r=exp, cnt=EBITS, acc=1, and go to SCAN. start_p in any other state is ignored.
- SCAN: one exponent bit per cycle. If e_r[EBITS-1]=1, set acc=base_r, shift e_r left, decrement cnt, and go to NEXT. Otherwise shift and decrement. If cnt reaches 0 with no set bit seen, go to DONE with acc=1 (exp=0 gives result 1).
- NEXT: if cnt=0, go to DONE. Otherwise go to SQ_ISSUE.
- SQ_ISSUE: mm_a=acc, mm_b=acc, mm_m=m_r, pulse mm_enable_p, go to SQ_WAIT.
- SQ_WAIT: on mm_done_irq_p, set acc=mm_y. If e_r[EBITS-1]=1, go to MUL_ISSUE. Else shift e_r, decrement cnt, go to NEXT.
- MUL_ISSUE: mm_a=acc, mm_b=base_r, mm_m=m_r, pulse mm_enable_p, go to MUL_WAIT.
- MUL_WAIT: on mm_done_irq_p, set acc=mm_y, shift e_r, decrement cnt, go to NEXT.
- DONE: result=acc, done_irq_p=1 for this cycle, busy=0, return to IDLE.
- mm_a/mm_b/mm_m are registered and held stable from the issue cycle through the matching done pulse, because the multiplier uses m every cycle.
- mm_done_irq_p outside SQ_WAIT/MUL_WAIT is ignored.
- Multiplier latency is never assumed; it varies with operand A.
- No arithmetic is done locally: all reduction is by the multiplier. Precondition violations (base >= m, m < 2) give an undefined result but the sequence still terminates.

## Timing
- start_p at cycle T: busy=1 from T+1.
- SCAN takes k+1 cycles, where k = number of leading zeros of exp; exp=0 takes EBITS cycles.
- Each multiplier operation costs 1 issue cycle + L multiplier cycles + 1 cycle (NEXT or transition).
- done_irq_p is asserted exactly once per accepted start_p, in the DONE cycle. result updates in that same cycle; busy is low in that cycle.
- At most one multiplier operation is outstanding; mm_enable_p is never high in two consecutive cycles.
- rst mid-operation: state goes to IDLE asynchronously, outputs take their reset values, and no done_irq_p is produced. A late mm_done_irq_p after reset is ignored.
- A new start_p is accepted in the cycle after DONE.

## Test plan
All scenarios use NBITS=16 and EBITS=16, with a behavioural multiplier stub of configurable latency (1 and 20 cycles).
- exp=0, base=5, m=7 -> result=1, zero mm_enable_p pulses, done_irq_p at T+1+16+1.
- base=3, exp=5, m=7 -> mm_enable_p pulses square(3,3), square(2,2), mul(4,3); result=5.
- base=2, exp=0xFFFF, m=0xFFF1 -> 15 squares + 15 muls (30 pulses); result=0x8000.
- base=0, exp=3, m=11 -> result=0.
- start_p re-pulsed while busy with different operands -> ignored; result matches the first operand set.
- rst asserted during SQ_WAIT -> busy, mm_enable_p and done_irq_p go to 0 at once. The stub's pending done is ignored. A following start_p (base=3, exp=5, m=7) yields 5.

Source files
------------

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod m.
// Issues square/multiply requests to an external modular multiplier and consumes its product.
module mod_exp_ctrl #(
  parameter int NBITS = 4096,
  parameter int EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             done_irq_p,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  output logic [NBITS-1:0] mm_m,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_irq_p
);

  localparam int CNT_W = $clog2(EBITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(EBITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NBITS-1:0] ACC_ONE  = NBITS'(1);

  typedef enum logic [2:0] {
    IDLE, SCAN, NEXT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] base_r;
  logic [NBITS-1:0] m_r;
  logic [NBITS-1:0] acc;
  logic [EBITS-1:0] e_r;
  logic             e_msb;

  assign e_msb = e_r[EBITS-1];

  // Control: sequencing, bit counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      result      <= '0;
      done_irq_p  <= 1'b0;
      mm_enable_p <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
      mm_m        <= '0;
    end else begin
      done_irq_p  <= 1'b0;
      mm_enable_p <= 1'b0;
      case (state)
        IDLE: begin
          if (start_p) begin
            cnt   <= CNT_FULL;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt - CNT_ONE;
          if (e_msb)               state <= NEXT;
          else if (cnt == CNT_ONE) state <= DONE;
        end
        NEXT: begin
          state <= (cnt == '0) ? DONE : SQ_ISSUE;
        end
        SQ_ISSUE: begin
          mm_a        <= acc;
          mm_b        <= acc;
          mm_m        <= m_r;
          mm_enable_p <= 1'b1;
          state       <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mm_done_irq_p) begin
            if (e_msb) begin
              state <= MUL_ISSUE;
            end else begin
              cnt   <= cnt - CNT_ONE;
              state <= NEXT;
            end
          end
        end
        MUL_ISSUE: begin
          mm_a        <= acc;
          mm_b        <= base_r;
          mm_m        <= m_r;
          mm_enable_p <= 1'b1;
          state       <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_done_irq_p) begin
            cnt   <= cnt - CNT_ONE;
            state <= NEXT;
          end
        end
        DONE: begin
          result     <= acc;
          done_irq_p <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, exponent shifter and accumulator (no reset needed).
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start_p) begin
          base_r <= base;
          m_r    <= m;
          e_r    <= exp;
          acc    <= ACC_ONE;
        end
      end
      SCAN: begin
        e_r <= e_r << 1;
        if (e_msb) acc <= base_r;
      end
      SQ_WAIT: begin
        if (mm_done_irq_p) begin
          acc <= mm_y;
          if (!e_msb) e_r <= e_r << 1;
        end
      end
      MUL_WAIT: begin
        if (mm_done_irq_p) begin
          acc <= mm_y;
          e_r <= e_r << 1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural multiplier stub plus modular-exponent reference model.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_p = 1'b0;
  logic [15:0] b_in = '0, e_in = '0, m_in = '0;
  logic        busy, done_irq_p, mm_enable_p;
  logic [15:0] result, mm_a, mm_b, mm_m;
  logic [15:0] mm_y = '0;
  logic        mm_done_irq_p = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, t_start = 0;
  int lat = 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
  } op_t;
  op_t exp_q[$];

  logic        busy_m = 1'b0, prev_en = 1'b0;
  logic [15:0] exp_res = '0, last_res = '0;
  int          n_en = 0, exp_nops = 0;

  logic        pend = 1'b0, stale = 1'b0;
  int          ctr = 0;
  logic [15:0] cap_a, cap_b, cap_m, prod;

  mod_exp_ctrl #(.NBITS(16), .EBITS(16)) dut (
    .clk(clk), .rst(rst), .start_p(start_p),
    .base(b_in), .exp(e_in), .m(m_in),
    .busy(busy), .result(result), .done_irq_p(done_irq_p),
    .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_y(mm_y), .mm_done_irq_p(mm_done_irq_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Right-to-left binary exponentiation: independent of the scan order used by the DUT.
  function automatic logic [15:0] modpow(input logic [15:0] b, input logic [15:0] e,
                                         input logic [15:0] mm);
    logic [63:0] r, x;
    r = 64'd1 % mm;
    x = b % mm;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[15:0];
  endfunction

  // Expected multiplier request sequence for a left-to-right scan of e.
  function automatic void build_ops(input logic [15:0] b, input logic [15:0] e,
                                    input logic [15:0] mm);
    int top;
    logic [63:0] acc;
    top = -1;
    for (int i = 0; i < 16; i++) if (e[i]) top = i;
    acc = 64'(b);
    for (int i = top - 1; i >= 0; i--) begin
      exp_q.push_back('{a: acc[15:0], b: acc[15:0], m: mm});
      acc = (acc * acc) % mm;
      if (e[i]) begin
        exp_q.push_back('{a: acc[15:0], b: b, m: mm});
        acc = (acc * 64'(b)) % mm;
      end
    end
  endfunction

  // Reference model and per-cycle output comparison.
  always @(negedge clk) begin
    if (rst) begin
      busy_m   = 1'b0;
      last_res = '0;
      exp_q.delete();
      n_en     = 0;
      prev_en  = 1'b0;
    end else begin
      if (mm_enable_p) begin
        chk("en_back_to_back", 64'(prev_en), 64'd0);
        n_en++;
      end
      prev_en = mm_enable_p;
      if (done_irq_p) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_only_when_busy", 64'(busy_m), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        chk("result", 64'(result), 64'(exp_res));
        chk("op_count", 64'(n_en), 64'(exp_nops));
        chk("ops_left", 64'(exp_q.size()), 64'd0);
        busy_m   = 1'b0;
        last_res = exp_res;
      end else begin
        chk("busy", 64'(busy), 64'(busy_m));
        chk("result_hold", 64'(result), 64'(last_res));
      end
      if (start_p && !busy_m) begin
        busy_m  = 1'b1;
        exp_res = modpow(b_in, e_in, m_in);
        exp_q.delete();
        build_ops(b_in, e_in, m_in);
        exp_nops = exp_q.size();
        n_en     = 0;
      end
    end
  end

  // Multiplier stub: latency counted from the cycle mm_enable_p is seen.
  always @(negedge clk) begin
    op_t op;
    int  l;
    mm_done_irq_p = 1'b0;
    if (rst) stale = 1'b1;
    if (pend) begin
      if (!stale && !rst) begin
        chk("mm_a_stable", 64'(mm_a), 64'(cap_a));
        chk("mm_b_stable", 64'(mm_b), 64'(cap_b));
        chk("mm_m_stable", 64'(mm_m), 64'(cap_m));
      end
      if (ctr == 0) begin
        mm_done_irq_p = 1'b1;
        mm_y          = prod;
        pend          = 1'b0;
      end else begin
        ctr--;
      end
    end
    if (mm_enable_p && !rst) begin
      chk("no_overlapping_op", 64'(pend), 64'd0);
      pend  = 1'b1;
      stale = 1'b0;
      cap_a = mm_a;
      cap_b = mm_b;
      cap_m = mm_m;
      prod  = 16'(((32'(cap_a) * 32'(cap_b)) % 32'(cap_m)));
      l     = (lat == 0) ? int'($urandom_range(1, 20)) : lat;
      ctr   = l - 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_op actual=%0h,%0h,%0h required=none", mm_a, mm_b, mm_m);
      end else begin
        op = exp_q.pop_front();
        chk("op_a", 64'(mm_a), 64'(op.a));
        chk("op_b", 64'(mm_b), 64'(op.b));
        chk("op_m", 64'(mm_m), 64'(op.m));
      end
    end
  end

  task automatic drive_start(input logic [15:0] b, input logic [15:0] e, input logic [15:0] mm);
    @(posedge clk);
    #1;
    b_in    = b;
    e_in    = e;
    m_in    = mm;
    start_p = 1'b1;
    t_start = cyc;
    @(posedge clk);
    #1;
    start_p = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 5000) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({name, "_completed"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic run(input logic [15:0] b, input logic [15:0] e, input logic [15:0] mm,
                     input string name);
    int d0;
    d0 = done_cnt;
    drive_start(b, e, mm);
    wait_done(d0, name);
  endtask

  initial begin
    int d0, i;
    logic [15:0] rb, re, rm;

    // Pin the reference model to hand-computed values.
    chk("pin_pow_3_5_7", 64'(modpow(16'd3, 16'd5, 16'd7)), 64'd5);
    chk("pin_pow_exp0", 64'(modpow(16'd5, 16'd0, 16'd7)), 64'd1);
    chk("pin_pow_2_ffff", 64'(modpow(16'd2, 16'hFFFF, 16'hFFF1)), 64'h8000);
    build_ops(16'd3, 16'd5, 16'd7);
    chk("pin_ops_n", 64'(exp_q.size()), 64'd3);
    chk("pin_op0", {16'd0, exp_q[0].a, exp_q[0].b, exp_q[0].m}, {16'd0, 16'd3, 16'd3, 16'd7});
    chk("pin_op1", {16'd0, exp_q[1].a, exp_q[1].b, exp_q[1].m}, {16'd0, 16'd2, 16'd2, 16'd7});
    chk("pin_op2", {16'd0, exp_q[2].a, exp_q[2].b, exp_q[2].m}, {16'd0, 16'd4, 16'd3, 16'd7});
    exp_q.delete();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done_irq_p), 64'd0);
    chk("rst_mm_en", 64'(mm_enable_p), 64'd0);
    chk("rst_mm_ops", {16'd0, mm_a, mm_b, mm_m}, 64'd0);
    rst = 1'b0;

    lat = 1;
    run(16'd5, 16'd0, 16'd7, "exp0");
    chk("exp0_result", 64'(result), 64'd1);
    chk("exp0_done_cycle", 64'(done_cyc), 64'(t_start + 18));
    chk("exp0_no_pulses", 64'(n_en), 64'd0);

    run(16'd3, 16'd5, 16'd7, "b3e5_lat1");
    chk("b3e5_lat1_result", 64'(result), 64'd5);
    lat = 20;
    run(16'd3, 16'd5, 16'd7, "b3e5_lat20");
    chk("b3e5_lat20_result", 64'(result), 64'd5);
    chk("b3e5_pulses", 64'(n_en), 64'd3);

    lat = 1;
    run(16'd2, 16'hFFFF, 16'hFFF1, "all_ones");
    chk("all_ones_result", 64'(result), 64'h8000);
    chk("all_ones_pulses", 64'(n_en), 64'd30);

    run(16'd0, 16'd3, 16'd11, "base0");
    chk("base0_result", 64'(result), 64'd0);

    // Second start while busy must be ignored.
    d0 = done_cnt;
    drive_start(16'd3, 16'd5, 16'd7);
    repeat (3) @(posedge clk);
    #1;
    b_in = 16'd2; e_in = 16'd7; m_in = 16'd11; start_p = 1'b1;
    @(posedge clk);
    #1;
    start_p = 1'b0;
    wait_done(d0, "repulse");
    chk("repulse_result", 64'(result), 64'd5);

    // Reset while waiting on a square; the stub's late done must be ignored.
    lat = 20;
    d0 = done_cnt;
    drive_start(16'd3, 16'd5, 16'd7);
    i = 0;
    while (!pend && i < 200) begin
      @(posedge clk);
      i++;
    end
    chk("rst_mid_reached_wait", 64'(pend), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_mm_en", 64'(mm_enable_p), 64'd0);
    chk("rst_mid_done", 64'(done_irq_p), 64'd0);
    chk("rst_mid_result", 64'(result), 64'd0);
    chk("rst_mid_mm_ops", {16'd0, mm_a, mm_b, mm_m}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i = 0;
    while (pend && i < 100) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_late_done_fired", 64'(pend), 64'd0);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    chk("rst_mid_idle", 64'(busy), 64'd0);
    lat = 1;
    run(16'd3, 16'd5, 16'd7, "after_rst");
    chk("after_rst_result", 64'(result), 64'd5);

    // Randomized operands, exponent lengths and multiplier latencies.
    for (int r = 0; r < 25; r++) begin
      rm  = 16'($urandom_range(2, 65535));
      rb  = 16'($urandom % 32'(rm));
      re  = 16'($urandom) >> $urandom_range(0, 15);
      lat = ($urandom_range(0, 2) == 0) ? 1 : 0;
      run(rb, re, rm, "random");
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
